// File: rtl/gpzda_sender_if.sv
// rtl/gpzda_sender_if.sv - byte stream handshake between the sentence builder and the UART
interface gpzda_sender_if #(
  parameter int B = 8
);
  logic         valid;
  logic         ready;
  logic [B-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gpzda_sender.sv
// rtl/gpzda_sender.sv - emits one $GPZDA sentence with XOR checksum and CR/LF per start request
module gpzda_sender #(
  parameter int B = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         time_bcd,
  input  logic [7:0]          day_bcd,
  input  logic [7:0]          month_bcd,
  input  logic [15:0]         year_bcd,
  gpzda_sender_if.master      tx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd37;

  state_t       state, state_n;
  logic [5:0]   idx;
  logic [5:0]   nidx;
  logic [7:0]   csum;
  logic [7:0]   cs_next;
  logic [7:0]   next_char;
  logic [B-1:0] data_q;
  logic         valid_q;
  logic [31:0]  time_q;
  logic [7:0]   day_q;
  logic [7:0]   month_q;
  logic [15:0]  year_q;
  logic         xfer;
  logic         accept;

  function automatic logic [7:0] dig(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer   = (state == SEND) && tx.ready;
  assign accept = (state != SEND) && start;
  assign nidx   = idx + 6'd1;

  // The byte leaving now (data_q, index idx) is folded in, so the
  // checksum is already final when index 34 is prepared.
  assign cs_next = ((idx >= 6'd1) && (idx <= 6'd32)) ? (csum ^ data_q[7:0]) : csum;

  always_comb begin
    next_char = 8'h00;
    case (nidx)
      6'd1:  next_char = "G";
      6'd2:  next_char = "P";
      6'd3:  next_char = "Z";
      6'd4:  next_char = "D";
      6'd5:  next_char = "A";
      6'd6:  next_char = ",";
      6'd7:  next_char = dig(time_q[31:28]);
      6'd8:  next_char = dig(time_q[27:24]);
      6'd9:  next_char = dig(time_q[23:20]);
      6'd10: next_char = dig(time_q[19:16]);
      6'd11: next_char = dig(time_q[15:12]);
      6'd12: next_char = dig(time_q[11:8]);
      6'd13: next_char = ".";
      6'd14: next_char = dig(time_q[7:4]);
      6'd15: next_char = dig(time_q[3:0]);
      6'd16: next_char = ",";
      6'd17: next_char = dig(day_q[7:4]);
      6'd18: next_char = dig(day_q[3:0]);
      6'd19: next_char = ",";
      6'd20: next_char = dig(month_q[7:4]);
      6'd21: next_char = dig(month_q[3:0]);
      6'd22: next_char = ",";
      6'd23: next_char = dig(year_q[15:12]);
      6'd24: next_char = dig(year_q[11:8]);
      6'd25: next_char = dig(year_q[7:4]);
      6'd26: next_char = dig(year_q[3:0]);
      6'd27: next_char = ",";
      6'd28: next_char = "0";
      6'd29: next_char = "0";
      6'd30: next_char = ",";
      6'd31: next_char = "0";
      6'd32: next_char = "0";
      6'd33: next_char = "*";
      6'd34: next_char = hex(cs_next[7:4]);
      6'd35: next_char = hex(cs_next[3:0]);
      6'd36: next_char = 8'h0D;
      6'd37: next_char = 8'h0A;
      default: next_char = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SEND;
      SEND: if (xfer && (idx == LAST_IDX)) state_n = DONE;
      DONE: state_n = start ? SEND : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 6'd0;
      csum    <= 8'h00;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      time_q  <= 32'h0;
      day_q   <= 8'h0;
      month_q <= 8'h0;
      year_q  <= 16'h0;
    end else begin
      state   <= state_n;
      valid_q <= (state_n == SEND);
      busy    <= (state_n == SEND);
      done    <= (state_n == DONE);
      if (accept) begin
        time_q  <= time_bcd;
        day_q   <= day_bcd;
        month_q <= month_bcd;
        year_q  <= year_bcd;
        idx     <= 6'd0;
        csum    <= 8'h00;
        data_q  <= B'(8'h24);
      end else if (xfer) begin
        idx    <= nidx;
        csum   <= cs_next;
        data_q <= (idx == LAST_IDX) ? '0 : B'(next_char);
      end
    end
  end

  assign tx.valid = valid_q;
  assign tx.data  = data_q;

endmodule

// File: tb/tb_gpzda_sender.sv
// tb/tb_gpzda_sender.sv - scoreboard bench for gpzda_sender with directed sentences
module tb_gpzda_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] time_bcd = '0;
  logic [7:0]  day_bcd = '0;
  logic [7:0]  month_bcd = '0;
  logic [15:0] year_bcd = '0;
  logic        busy;
  logic        done;

  gpzda_sender_if #(.B(8)) tx ();

  gpzda_sender #(.B(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .time_bcd  (time_bcd),
    .day_bcd   (day_bcd),
    .month_bcd (month_bcd),
    .year_bcd  (year_bcd),
    .tx        (tx.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         xfer_cnt = 0;
  logic [7:0] exp_q[$];
  logic       rdy_toggle = 1'b0;
  int         phase = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held = 8'h00;

  localparam string S1 = "$GPZDA,123519.00,04,07,2021,00,00*69";
  localparam string S0 = "$GPZDA,000000.00,00,00,0000,00,00*66";

  // ready pattern 1,0,0,1 when toggling is enabled
  always @(posedge clock) begin
    #1;
    if (rdy_toggle) begin
      tx.ready = (phase == 0 || phase == 3);
      phase = (phase + 1) % 4;
    end else begin
      tx.ready = 1'b1;
    end
  end

  // monitor: pops the scoreboard on every transfer and checks stall hold
  always @(negedge clock) begin
    if (!reset) begin
      if (stall_prev) begin
        checks++;
        if (!(tx.valid && tx.data === held)) begin
          failures++;
          $display("FAIL hold: valid=%0b data=%02h required valid=1 data=%02h", tx.valid, tx.data, held);
        end
      end
      if (tx.valid && tx.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte: data=%02h required no transfer", tx.data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx.data !== e) begin
            failures++;
            $display("FAIL byte%0d: data=%02h required %02h", xfer_cnt, tx.data, e);
          end
        end
        xfer_cnt++;
      end
      stall_prev = tx.valid && !tx.ready;
      held = tx.data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_sentence(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_fields(input logic [31:0] t, input logic [7:0] d, input logic [7:0] m,
                            input logic [15:0] y);
    time_bcd = t; day_bcd = d; month_bcd = m; year_bcd = y;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("valid_after_start", {31'b0, tx.valid}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, {31'b0, done}, 32'd1);
    check({name, "_valid_at_done"}, {31'b0, tx.valid}, 32'd0);
    check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    tick();
    check({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    check({name, "_all_bytes"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (xfer_cnt < target && n < 400) begin
      tick();
      n++;
    end
    check("byte_count_reached", {31'b0, xfer_cnt >= target}, 32'd1);
  endtask

  initial begin
    tx.ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", {31'b0, tx.valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", {24'b0, tx.data}, 32'h00);

    // sentence 1, ready held high
    set_fields(32'h12351900, 8'h04, 8'h07, 16'h2021);
    push_sentence(S1);
    pulse_start();
    wait_done("s1");

    // all zero fields
    set_fields(32'h0, 8'h0, 8'h0, 16'h0);
    push_sentence(S0);
    pulse_start();
    wait_done("s0");

    // ready toggling
    rdy_toggle = 1'b1;
    set_fields(32'h12351900, 8'h04, 8'h07, 16'h2021);
    push_sentence(S1);
    pulse_start();
    wait_done("toggle");
    rdy_toggle = 1'b0;
    tick();

    // start during busy and input changes after acceptance
    begin
      int base;
      int seen;
      base = xfer_cnt;
      set_fields(32'h12351900, 8'h04, 8'h07, 16'h2021);
      push_sentence(S1);
      pulse_start();
      set_fields(32'h99999999, 8'h31, 8'h12, 16'h1999);
      wait_bytes(base + 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("busy_start");
      seen = 0;
      for (int i = 0; i < 45; i++) begin
        if (tx.valid || busy) seen = 1;
        tick();
      end
      check("no_second_sentence", seen, 32'd0);
    end

    // reset mid-sentence
    begin
      int base;
      base = xfer_cnt;
      set_fields(32'h12351900, 8'h04, 8'h07, 16'h2021);
      push_sentence(S1);
      pulse_start();
      wait_bytes(base + 20);
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      check("midrst_valid", {31'b0, tx.valid}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_data", {24'b0, tx.data}, 32'h00);
      check("midrst_done", {31'b0, done}, 32'd0);
      tick();
      push_sentence(S1);
      pulse_start();
      wait_done("after_rst");
    end

    // start on the done cycle chains a second independent sentence
    begin
      int n;
      set_fields(32'h12351900, 8'h04, 8'h07, 16'h2021);
      push_sentence(S1);
      pulse_start();
      n = 0;
      while (!done && n < 400) begin
        tick();
        n++;
      end
      check("chain_done_seen", {31'b0, done}, 32'd1);
      set_fields(32'h0, 8'h0, 8'h0, 16'h0);
      push_sentence(S0);
      pulse_start();
      wait_done("chain");
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
